mem_arb: RTL
============

# mem_arb

Two-requester arbiter and sequencer for the byte-addressed `mem` block, sitting between the instruction-fetch port (requester 0), the load/store port (requester 1) and the memory. It grants at most one access per cycle with round-robin fairness and drives the memory's read and write ports. It returns a registered, one-cycle-latency response to the granted requester, optionally with address-range and alignment error checking.

## Interface
Parameters:
- `MEM_BYTES`, 128, memory size in bytes; must be a multiple of 4.
- `ADRS_W`, 32, address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid[1:0]` in 2: request valid, one bit per requester.
- `req_ready[1:0]` out 2: request accepted this cycle; one-hot or zero.
- `req_wr[1:0]` in 2: 1 = write, 0 = read.
- `req_adrs0`, `req_adrs1` in `ADRS_W`: byte address.
- `req_byt_en0`, `req_byt_en1` in 4: byte enables, writes only.
- `req_wr_data0`, `req_wr_data1` in 32: write data.
- `rsp_valid[1:0]` out 2: response valid, one-hot or zero.
- `rsp_data` out 32: read data; 0 for writes and errors.
- `rsp_err` out 1: access rejected; meaningful only with `rsp_valid`.
- `adrs_rd` out `ADRS_W`: to memory read address.
- `rd_data` in 32: from memory, combinational read.
- `wr_en` out 1: to memory write enable.
- `byt_en` out 4: to memory byte enables.
- `adrs_wr` out `ADRS_W`: to memory write address.
- `wr_data` out 32: to memory write data.

## Operation
Arbitration (combinational, each cycle):
- One valid: that requester is granted.
- Both valid: the requester not granted most recently wins. `last_gnt` is a 1-bit register updated on every grant.
- `req_ready[g] = 1` for the granted requester g only. A request transfers when valid and ready are both high.
- Requests must hold stable until accepted. A non-granted requester keeps waiting.

Memory drive:
- Read: `adrs_rd` = granted address, `wr_en` = 0.
- Write: `adrs_wr`, `byt_en`, `wr_data` come from the granted requester, `wr_en` = 1. The memory commits the write at the same clock edge.
- `wr_en` is 0 whenever there is no grant, the request is a read, or the request is rejected.
- `adrs_rd` / `adrs_wr` outputs are don't-care when unused, but are driven from the granted or requester-0 mux and never X.

Response register, loaded at the accept edge:
- `rsp_valid` = one-hot of the granted requester.
- `rsp_data` = `rd_data` for reads, 0 for writes.
- `rsp_err` as per Configuration.
- There is no response back-pressure. Requesters must sample `rsp_*` in the cycle it is valid.

Ordering:
- The write and read ports are one access per cycle in total.
- A read accepted in cycle N+1 observes a write accepted in cycle N.

## Timing
Reset:
- `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0, `last_gnt` = 1 (so requester 0 wins the first contention).
- While `rst` is high: `req_ready` = 0, `wr_en` = 0.

Latency and throughput:
- Accept at edge N, response valid in cycle N+1 for exactly one cycle.
- Throughput is one access per cycle, back-to-back with no bubble.
- A single requester can issue every cycle and is granted every cycle.

Contention:
- With both requesters valid continuously, grants alternate 0, 1, 0, 1…
- Maximum wait for either requester is 1 cycle.

Reset mid-operation:
- Any pending response is dropped, with `rsp_valid` forced 0 asynchronously.
- A write already committed to memory stays committed.
- A write presented in the cycle that reset asserts is not performed.

## Configuration
`MEM_ARB_CHK_EN` defined:
- A request is rejected if `adrs[1:0] != 0` or `adrs > MEM_BYTES-4`.
- A rejected request is still accepted (ready = 1) and consumes the grant and the round-robin turn.
- It never asserts `wr_en`.
- It responds next cycle with `rsp_err` = 1 and `rsp_data` = 0.

`MEM_ARB_CHK_EN` undefined:
- No checking; addresses pass through unmodified.
- `rsp_err` is tied 0.

## Test plan
- Reset, then requester 0 writes 0xDEADBEEF to address 0x10 with `byt_en` 0xF, then reads 0x10 → write response `rsp_valid` = 01, `rsp_data` = 0; read response `rsp_data` = 0xDEADBEEF one cycle after accept.
- Both requesters hold valid reads for 6 cycles from reset → grants 0,1,0,1,0,1; `rsp_valid` alternates 01/10 one cycle behind.
- Requester 1 writes 0x11223344 to 0x20 with `byt_en` 0x5 over prior 0xFFFFFFFF, then requester 0 reads 0x20 in the next cycle → 0xFF22FF44.
- With `MEM_ARB_CHK_EN`, write to 0x7E, then write to 0x80 → both give `rsp_err` = 1, `wr_en` never high, memory unchanged; a read of 0x7C succeeds with `rsp_err` = 0.
- Assert `rst` asynchronously mid-cycle with a read accepted on the previous edge → `rsp_valid` drops to 0 immediately; after release, the first contended grant goes to requester 0.
- Requester 0 issues 8 back-to-back reads with requester 1 idle → `req_ready[0]` stays high for all 8 cycles; 8 consecutive responses.

Source files
------------

// File: rtl/mem_arb_if.sv
// Request/response and memory-drive bundle for mem_arb.
// The slave modport is the arbiter; the master modport covers the requesters and memory.
interface mem_arb_if #(
    parameter int ADRS_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_wr;
    logic [ADRS_W-1:0] req_adrs0;
    logic [ADRS_W-1:0] req_adrs1;
    logic [3:0]        req_byt_en0;
    logic [3:0]        req_byt_en1;
    logic [31:0]       req_wr_data0;
    logic [31:0]       req_wr_data1;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic [ADRS_W-1:0] adrs_rd;
    logic [31:0]       rd_data;
    logic              wr_en;
    logic [3:0]        byt_en;
    logic [ADRS_W-1:0] adrs_wr;
    logic [31:0]       wr_data;

    modport slave (
        input  req_valid, req_wr, req_adrs0, req_adrs1, req_byt_en0, req_byt_en1,
               req_wr_data0, req_wr_data1, rd_data,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               adrs_rd, wr_en, byt_en, adrs_wr, wr_data
    );

    modport master (
        output req_valid, req_wr, req_adrs0, req_adrs1, req_byt_en0, req_byt_en1,
               req_wr_data0, req_wr_data1, rd_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               adrs_rd, wr_en, byt_en, adrs_wr, wr_data
    );
endinterface

// File: rtl/mem_arb.sv
// Two-requester round-robin arbiter in front of the byte-addressed memory, one access per cycle.
// Define MEM_ARB_CHK_EN to reject misaligned or out-of-range addresses with rsp_err.
module mem_arb #(
    parameter int MEM_BYTES = 128,
    parameter int ADRS_W    = 32
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);
    logic              last_gnt_q, last_gnt_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic              gnt_vld;
    logic              gnt;
    logic              sel_wr;
    logic              sel_err;
    logic [ADRS_W-1:0] sel_adrs;

    // Contention goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        gnt_vld  = (bus.req_valid != 2'b00) && !rst;
        gnt      = (bus.req_valid == 2'b11) ? ~last_gnt_q : bus.req_valid[1];
        sel_adrs = gnt ? bus.req_adrs1 : bus.req_adrs0;
        sel_wr   = bus.req_wr[gnt];
    end

`ifdef MEM_ARB_CHK_EN
    assign sel_err = (sel_adrs[1:0] != 2'b00) || (sel_adrs > ADRS_W'(MEM_BYTES - 4));
`else
    assign sel_err = 1'b0;
`endif

    assign bus.req_ready = gnt_vld ? {gnt, ~gnt} : 2'b00;
    assign bus.wr_en     = gnt_vld && sel_wr && !sel_err;
    assign bus.adrs_rd   = sel_adrs;
    assign bus.adrs_wr   = sel_adrs;
    assign bus.byt_en    = gnt ? bus.req_byt_en1 : bus.req_byt_en0;
    assign bus.wr_data   = gnt ? bus.req_wr_data1 : bus.req_wr_data0;

    always_comb begin
        rsp_valid_d = bus.req_ready;
        rsp_data_d  = (gnt_vld && !sel_wr && !sel_err) ? bus.rd_data : 32'h0;
        rsp_err_d   = gnt_vld && sel_err;
        last_gnt_d  = gnt_vld ? gnt : last_gnt_q;
    end

    // last_gnt resets to 1 so requester 0 takes the first contended grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
            last_gnt_q  <= 1'b1;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            last_gnt_q  <= last_gnt_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
